// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared constants, field offsets and state types for the date/time text path
package time_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_2     = 8'h32;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_DASH  = 8'h2D;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_CR    = 8'h0D;

  localparam int FRAME_LEN = 20;
  localparam int LAST_IDX  = FRAME_LEN - 1;

  // Bit offsets of each BCD byte inside the 48-bit word, shared with the sender
  localparam int OFF_YY = 40;
  localparam int OFF_MM = 32;
  localparam int OFF_DD = 24;
  localparam int OFF_HH = 16;
  localparam int OFF_MI = 8;
  localparam int OFF_SS = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_t;

  typedef enum logic [1:0] {SLOT_DIGIT, SLOT_LIT, SLOT_END} slot_kind_t;

  typedef struct packed {
    slot_kind_t kind;
    logic [7:0] lit;
    logic [3:0] nib;
  } slot_t;

  // What the frame expects at byte index idx; nib is the nibble slot (11 = YY tens)
  function automatic slot_t slot_of(input logic [4:0] idx);
    slot_t s;
    s.kind = SLOT_END;
    s.lit  = 8'h00;
    s.nib  = 4'd0;
    case (idx)
      5'd1:  begin s.kind = SLOT_LIT;   s.lit = ASC_0;                  end
      5'd2:  begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_YY / 4 + 1);     end
      5'd3:  begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_YY / 4);         end
      5'd4:  begin s.kind = SLOT_LIT;   s.lit = ASC_DASH;               end
      5'd5:  begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_MM / 4 + 1);     end
      5'd6:  begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_MM / 4);         end
      5'd7:  begin s.kind = SLOT_LIT;   s.lit = ASC_DASH;               end
      5'd8:  begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_DD / 4 + 1);     end
      5'd9:  begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_DD / 4);         end
      5'd10: begin s.kind = SLOT_LIT;   s.lit = ASC_SPACE;              end
      5'd11: begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_HH / 4 + 1);     end
      5'd12: begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_HH / 4);         end
      5'd13: begin s.kind = SLOT_LIT;   s.lit = ASC_COLON;              end
      5'd14: begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_MI / 4 + 1);     end
      5'd15: begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_MI / 4);         end
      5'd16: begin s.kind = SLOT_LIT;   s.lit = ASC_COLON;              end
      5'd17: begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_SS / 4 + 1);     end
      5'd18: begin s.kind = SLOT_DIGIT; s.nib = 4'(OFF_SS / 4);         end
      5'(LAST_IDX): s.kind = SLOT_END;
      default: s.kind = SLOT_END;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_recv_if.sv
// rtl/time_recv_if.sv - UART byte input and parsed date/time outputs of the receiver
interface time_recv_if;

  logic        uart_rx_done;
  logic [7:0]  uart_rx_data;
  logic [47:0] date_time;
  logic        date_time_set;
  logic        frame_err;
  logic        busy;

  modport master (
    output uart_rx_done, uart_rx_data,
    input  date_time, date_time_set, frame_err, busy
  );

  modport slave (
    input  uart_rx_done, uart_rx_data,
    output date_time, date_time_set, frame_err, busy
  );

endinterface

// File: rtl/bcd_range_chk.sv
// rtl/bcd_range_chk.sv - combinational legality check of a packed BCD date/time word
module bcd_range_chk
  import time_pkg::*;
(
  input  logic [47:0] bcd,
  output logic        ok
);

  logic [7:0] mm, dd, hh, mi, ss;
  logic       digits_ok;

  assign mm = bcd[OFF_MM +: 8];
  assign dd = bcd[OFF_DD +: 8];
  assign hh = bcd[OFF_HH +: 8];
  assign mi = bcd[OFF_MI +: 8];
  assign ss = bcd[OFF_SS +: 8];

  // Valid BCD digits compare correctly as plain unsigned bytes
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bcd[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  assign ok = digits_ok
           && (mm >= 8'h01) && (mm <= 8'h12)
           && (dd >= 8'h01) && (dd <= 8'h31)
           && (hh <= 8'h23)
           && (mi <= 8'h59)
           && (ss <= 8'h59);

endmodule

// File: rtl/time_recv.sv
// rtl/time_recv.sv - parses "20YY-MM-DD hh:mm:ss\n" from the UART into BCD and requests an RTC set
module time_recv #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input logic        clk,
  input logic        rst,
  time_recv_if.slave bus
);
  import time_pkg::*;

  localparam int              CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state, state_n;
  logic [4:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cr_seen, cr_seen_n;
  logic [47:0]   shadow, shadow_n;
  logic [47:0]   dt, dt_n;
  logic          set_q, set_n;
  logic          err_q, err_n;
  logic          range_ok;
  logic          is_digit;
  logic          expired;
  slot_t         slot;

  bcd_range_chk u_chk (
    .bcd (shadow),
    .ok  (range_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      cr_seen <= 1'b0;
      shadow  <= '0;
      dt      <= '0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      cr_seen <= cr_seen_n;
      shadow  <= shadow_n;
      dt      <= dt_n;
      set_q   <= set_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    cr_seen_n = cr_seen;
    shadow_n  = shadow;
    dt_n      = dt;
    set_n     = 1'b0;
    err_n     = 1'b0;
    slot      = slot_of(idx);
    is_digit  = (bus.uart_rx_data >= ASC_0) && (bus.uart_rx_data <= ASC_9);
    expired   = (cnt == CNT_LAST);

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (bus.uart_rx_done && bus.uart_rx_data == ASC_2) begin
          state_n   = ST_RECV;
          idx_n     = 5'd1;
          cr_seen_n = 1'b0;
        end
      end

      ST_RECV: begin
        // A byte arriving on the expiry cycle takes precedence over the timeout
        if (bus.uart_rx_done) begin
          cnt_n = '0;
          if (slot.kind == SLOT_DIGIT && is_digit) begin
            shadow_n[{slot.nib, 2'b00} +: 4] = bus.uart_rx_data[3:0];
            idx_n = idx + 5'd1;
          end else if (slot.kind == SLOT_LIT && bus.uart_rx_data == slot.lit) begin
            idx_n = idx + 5'd1;
          end else if (slot.kind == SLOT_END && bus.uart_rx_data == ASC_LF) begin
            state_n = ST_IDLE;
            idx_n   = '0;
            if (range_ok) begin
              dt_n  = shadow;
              set_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else if (slot.kind == SLOT_END && bus.uart_rx_data == ASC_CR && !cr_seen) begin
            cr_seen_n = 1'b1;
          end else begin
            err_n   = 1'b1;
            idx_n   = '0;
            state_n = (bus.uart_rx_data == ASC_LF) ? ST_IDLE : ST_DROP;
          end
        end else if (expired) begin
          state_n = ST_IDLE;
          idx_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_DROP: begin
        if (bus.uart_rx_done) begin
          cnt_n = '0;
          if (bus.uart_rx_data == ASC_LF) state_n = ST_IDLE;
        end else if (expired) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.date_time     = dt;
  assign bus.date_time_set = set_q;
  assign bus.frame_err     = err_q;
  assign bus.busy          = (state != ST_IDLE);

endmodule
